// File: rtl/spi_host_pkg.sv
// Shared types for the byte-oriented SPI host: FSM state encoding and byte width.
package spi_host_pkg;

    localparam int SpiByteW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } spi_host_state_e;

    // CSB is asserted in every state that belongs to an open frame.
    function automatic logic state_in_frame(spi_host_state_e s);
        return (s == ST_LEAD) || (s == ST_HIGH) || (s == ST_LOW) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_host_tick.sv
// Half-period counter: restarts on clr_i and flags the last cycle of each SCK half-period.
module spi_host_tick #(
    parameter int ClkDiv = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (r_cnt == CntMax) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign tick_o = (r_cnt == CntMax);

endmodule

// File: rtl/spi_host_byte.sv
// SPI mode-0 host, MSB first: one byte per valid/ready handshake, received byte
// returned on a single-cycle pulse; tx_last_i closes the frame (CSB high) after the byte.
module spi_host_byte
    import spi_host_pkg::*;
#(
    parameter int ClkDiv = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    input  logic [SpiByteW-1:0] tx_data_i,
    input  logic                tx_last_i,
    output logic                rx_valid_o,
    output logic [SpiByteW-1:0] rx_data_o,
    output logic                busy_o,
    output logic                spi_sck_o,
    output logic                spi_csb_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i
);

    localparam int BitW = $clog2(SpiByteW);
    localparam logic [BitW-1:0] LastBit = BitW'(SpiByteW - 1);

    spi_host_state_e     r_state, w_state_next;
    logic [SpiByteW-1:0] r_sr, w_sr_next;
    logic [BitW-1:0]     r_bit_cnt, w_bit_cnt_next;
    logic                r_last, w_last_next;
    logic                w_tick, w_clr, w_accept, w_rx_done;

    logic                r_sck, r_csb, r_mosi, r_rx_valid, r_busy;
    logic [SpiByteW-1:0] r_rx_data;

    spi_host_tick #(
        .ClkDiv (ClkDiv)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_clr),
        .tick_o (w_tick)
    );

    assign tx_ready_o = !rst_i && ((r_state == ST_IDLE) || (r_state == ST_HOLD));
    assign w_accept   = tx_valid_i && tx_ready_o;
    // Every state change restarts the half-period count.
    assign w_clr      = (w_state_next != r_state);

    always_comb begin
        w_state_next   = r_state;
        w_sr_next      = r_sr;
        w_bit_cnt_next = r_bit_cnt;
        w_last_next    = r_last;
        w_rx_done      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept) begin
                    w_sr_next      = tx_data_i;
                    w_last_next    = tx_last_i;
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (w_tick) w_state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_sr_next    = {r_sr[SpiByteW-2:0], spi_miso_i};
                    w_state_next = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    if (r_bit_cnt == LastBit) begin
                        w_rx_done    = 1'b1;
                        w_state_next = r_last ? ST_GAP : ST_HOLD;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BitW'(1);
                        w_state_next   = ST_HIGH;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pad outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_last     <= 1'b0;
            r_sck      <= 1'b0;
            r_csb      <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sr       <= w_sr_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_last     <= w_last_next;
            r_sck      <= (w_state_next == ST_HIGH);
            r_csb      <= !state_in_frame(w_state_next);
            r_mosi     <= ((w_state_next == ST_LEAD) || (w_state_next == ST_HIGH) ||
                           (w_state_next == ST_LOW)) ? w_sr_next[SpiByteW-1] : 1'b0;
            r_rx_valid <= w_rx_done;
            r_busy     <= (w_state_next != ST_IDLE);
            if (w_rx_done) r_rx_data <= w_sr_next;
        end
    end

    assign spi_sck_o  = r_sck;
    assign spi_csb_o  = r_csb;
    assign spi_mosi_o = r_mosi;
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_spi_host_byte.sv
// Directed bench for spi_host_byte: a D=4 instance with a mode-0 device model and a
// D=1 instance in MOSI->MISO loopback.
module tb_spi_host_byte;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst;
    logic       tx_valid, tx_last, tx_ready, rx_valid, busy, sck, csb, mosi, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid1, tx_last1, tx_ready1, rx_valid1, busy1, sck1, csb1, mosi1, miso1;
    logic [7:0] tx_data1, rx_data1;

    assign miso1 = mosi1;

    spi_host_byte #(.ClkDiv(4)) dut (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .tx_data_i(tx_data), .tx_last_i(tx_last), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
        .busy_o(busy), .spi_sck_o(sck), .spi_csb_o(csb), .spi_mosi_o(mosi), .spi_miso_i(miso)
    );

    spi_host_byte #(.ClkDiv(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid1), .tx_ready_o(tx_ready1),
        .tx_data_i(tx_data1), .tx_last_i(tx_last1), .rx_valid_o(rx_valid1), .rx_data_o(rx_data1),
        .busy_o(busy1), .spi_sck_o(sck1), .spi_csb_o(csb1), .spi_mosi_o(mosi1), .spi_miso_i(miso1)
    );

    int total = 0;
    int bad   = 0;
    int t0    = 0;

    // Device model and monitors, all updated on the falling clock edge.
    logic       prev_sck = 1'b0, prev_csb = 1'b1, prev_sck1 = 1'b0;
    logic [2:0] idx = 3'd0;
    int         rise_cnt = 0;
    logic [7:0] dev_rx = 8'h00, dev_tx = 8'h00;
    logic [7:0] dev_bytes[$];
    int         rx_cnt = 0, last_rx_cyc = 0, csb_rises = 0;
    int         rises1 = 0, rx1_cnt = 0, rx1_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst) begin
            idx      = 3'd0;
            rise_cnt = 0;
            prev_sck = 1'b0;
            prev_csb = 1'b1;
            prev_sck1 = 1'b0;
        end else begin
            if (sck && !prev_sck) begin
                dev_rx = {dev_rx[6:0], mosi};
                rise_cnt++;
                if (rise_cnt == 8) begin
                    dev_bytes.push_back(dev_rx);
                    rise_cnt = 0;
                end
            end
            if (!sck && prev_sck) idx = idx + 3'd1;
            if (csb && !prev_csb) csb_rises++;
            if (rx_valid) begin
                rx_cnt++;
                last_rx_cyc = cyc;
            end
            if (sck1 && !prev_sck1) rises1++;
            if (rx_valid1) begin
                rx1_cnt++;
                rx1_cyc = cyc;
            end
            prev_sck  = sck;
            prev_csb  = csb;
            prev_sck1 = sck1;
        end
        miso = dev_tx[3'd7 - idx];
    endtask

    task automatic offer(input logic [7:0] d, input logic l);
        chk("accept_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        t0       = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) tx_valid = 1'b0;
        end
    endtask

    logic [7:0] lb [3];
    int         t_acc;

    initial begin
        rst = 1'b1; miso = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        tx_valid1 = 1'b0; tx_data1 = 8'h00; tx_last1 = 1'b0;
        lb[0] = 8'hFF; lb[1] = 8'h00; lb[2] = 8'h81;
        repeat (3) step();
        chk("rst_pads", {26'd0, csb, sck, mosi, rx_valid, busy, tx_ready}, 32'b100000);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        rst = 1'b0;
        step();
        chk("post_rst", {29'd0, csb, busy, tx_ready}, 32'b101);

        // Single-byte frame, D=4: device returns 0x3C.
        dev_tx = 8'h3C; dev_bytes.delete(); rx_cnt = 0;
        offer(8'hA5, 1'b1);
        for (int r = 1; r <= 73; r++) begin
            step();
            if (r == 1) tx_valid = 1'b0;
            chk("t1_csb", {31'd0, csb}, (r >= 1 && r <= 68) ? 32'd0 : 32'd1);
            chk("t1_rxv", {31'd0, rx_valid}, (r == 69) ? 32'd1 : 32'd0);
            chk("t1_ready", {31'd0, tx_ready}, (r == 73) ? 32'd1 : 32'd0);
            chk("t1_sck", {31'd0, sck}, (r >= 5 && r <= 68 && ((r - 5) % 8) < 4) ? 32'd1 : 32'd0);
        end
        chk("t1_dev_n", dev_bytes.size(), 1);
        chk("t1_dev_byte", {24'd0, dev_bytes[0]}, 32'hA5);
        chk("t1_rx_data", {24'd0, rx_data}, 32'h3C);
        chk("t1_rx_cyc", last_rx_cyc - t0, 69);

        // Two-byte frame with tx_valid held across the boundary.
        dev_tx = 8'h96; dev_bytes.delete(); rx_cnt = 0; csb_rises = 0; t_acc = -1;
        offer(8'h12, 1'b0);
        for (int r = 1; r <= 142; r++) begin
            step();
            if (r == 1) begin
                tx_data = 8'h34;
                tx_last = 1'b1;
            end
            if (t_acc >= 0 && r > t_acc) tx_valid = 1'b0;
            else if (tx_valid && tx_ready && t_acc < 0) t_acc = r;
            if (r <= 137) chk("t2_csb", {31'd0, csb}, 32'd0);
        end
        tx_valid = 1'b0;
        chk("t2_accept2", t_acc, 69);
        chk("t2_dev_n", dev_bytes.size(), 2);
        chk("t2_dev0", {24'd0, dev_bytes[0]}, 32'h12);
        chk("t2_dev1", {24'd0, dev_bytes[1]}, 32'h34);
        chk("t2_rx_cnt", rx_cnt, 2);
        chk("t2_csb_rises", csb_rises, 1);
        chk("t2_ready", {31'd0, tx_ready}, 32'd1);

        // D=1 loopback.
        for (int k = 0; k < 3; k++) begin
            chk("t3_ready", {31'd0, tx_ready1}, 32'd1);
            tx_data1 = lb[k]; tx_last1 = 1'b1; tx_valid1 = 1'b1;
            t0 = cyc; rises1 = 0; rx1_cnt = 0;
            for (int r = 1; r <= 19; r++) begin
                step();
                if (r == 1) begin
                    tx_valid1 = 1'b0;
                    chk("t3_busy", {31'd0, busy1}, 32'd1);
                end
            end
            chk("t3_rx_data", {24'd0, rx_data1}, {24'd0, lb[k]});
            chk("t3_rises", rises1, 8);
            chk("t3_rx_cnt", rx1_cnt, 1);
            chk("t3_rx_cyc", rx1_cyc - t0, 18);
            chk("t3_idle", {30'd0, csb1, tx_ready1}, 32'b11);
        end

        // HOLD for 100 cycles, then close the frame.
        dev_tx = 8'h00; dev_bytes.delete(); rx_cnt = 0;
        offer(8'hC7, 1'b0);
        run(69);
        for (int h = 0; h < 100; h++) begin
            step();
            chk("t4_hold", {29'd0, csb, sck, tx_ready}, 32'b001);
        end
        offer(8'hE1, 1'b1);
        run(73);
        chk("t4_dev_n", dev_bytes.size(), 2);
        chk("t4_dev1", {24'd0, dev_bytes[1]}, 32'hE1);
        chk("t4_rx_cnt", rx_cnt, 2);
        chk("t4_ready", {31'd0, tx_ready}, 32'd1);

        // Reset in bit 3 (HIGH phase covers 29..32).
        dev_tx = 8'h3C; dev_bytes.delete(); rx_cnt = 0;
        offer(8'h6B, 1'b1);
        run(30);
        rst = 1'b1;
        step();
        chk("t5_abort", {26'd0, csb, sck, mosi, rx_valid, busy, tx_ready}, 32'b100000);
        chk("t5_rx_data", {24'd0, rx_data}, 32'h00);
        rst = 1'b0;
        step();
        chk("t5_after", {29'd0, csb, busy, tx_ready}, 32'b101);
        run(80);
        chk("t5_no_rxv", rx_cnt, 0);
        chk("t5_no_dev", dev_bytes.size(), 0);
        dev_tx = 8'h5E;
        offer(8'hA1, 1'b1);
        run(73);
        chk("t5_rx_data2", {24'd0, rx_data}, 32'h5E);
        chk("t5_dev_n", dev_bytes.size(), 1);
        chk("t5_dev0", {24'd0, dev_bytes[0]}, 32'hA1);
        chk("t5_rx_cnt", rx_cnt, 1);

        // tx_valid held through GAP: next accept only once IDLE is reached.
        dev_tx = 8'h77; dev_bytes.delete(); rx_cnt = 0; t_acc = -1;
        offer(8'h4D, 1'b1);
        for (int r = 1; r <= 146; r++) begin
            step();
            if (r == 1) tx_data = 8'hB2;
            if (t_acc >= 0 && r > t_acc) tx_valid = 1'b0;
            else if (tx_valid && tx_ready && t_acc < 0) t_acc = r;
            if (r >= 69 && r <= 72) chk("t6_gap", {29'd0, csb, busy, tx_ready}, 32'b110);
        end
        tx_valid = 1'b0;
        chk("t6_accept2", t_acc, 73);
        chk("t6_dev_n", dev_bytes.size(), 2);
        chk("t6_dev0", {24'd0, dev_bytes[0]}, 32'h4D);
        chk("t6_dev1", {24'd0, dev_bytes[1]}, 32'hB2);
        chk("t6_rx_data", {24'd0, rx_data}, 32'h77);
        chk("t6_rx_cnt", rx_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_host_byte.md
# spi_host_byte

Byte-oriented SPI host (mode 0, MSB first) for FPGA bring-up: drives the chip's `spi_device` pads (SCK/CSB/MOSI/MISO) from a bench-side or board-side controller, e.g. to push bootstrap images over the DPS pins when SPI mode is strapped. It accepts one byte per valid/ready handshake, shifts it out while capturing MISO, and returns the received byte. A frame-end flag controls CSB.

## Interface
- `ClkDiv`, default 4: SCK half-period in `clk_i` cycles; legal range ≥1.
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `tx_valid_i`  in  1  byte offered.
- `tx_ready_o`  out  1  host can accept a byte this cycle.
- `tx_data_i`  in  8  byte to send, MSB first.
- `tx_last_i`  in  1  deassert CSB after this byte (frame end).
- `rx_valid_o`  out  1  one-cycle pulse; `rx_data_o` valid. No backpressure.
- `rx_data_o`  out  8  byte captured from MISO.
- `busy_o`  out  1  high in any state except IDLE.
- `spi_sck_o`  out  1  SPI clock, idles low.
- `spi_csb_o`  out  1  chip select, active low.
- `spi_mosi_o`  out  1  host data out.
- `spi_miso_i`  in  1  device data in; assumed synchronised externally.

## Operation
- FSM states: IDLE, LEAD, HIGH, LOW, HOLD, GAP. Half-period counter `cnt` clears on every state entry; `tick` = (`cnt == ClkDiv-1`).
- IDLE: csb=1, sck=0, ready=1. On `tx_valid_i & tx_ready_o`: load shift reg `sr` with data, latch `last`, `bit_cnt`=0, enter LEAD.
- LEAD: csb=0, sck=0, mosi=`sr[7]`. On tick, enter HIGH.
- HIGH: sck=1. On tick: `sr <= {sr[6:0], spi_miso_i}` (sample at end of high phase), enter LOW. MOSI therefore changes at the falling edge.
- LOW: sck=0. On tick: if `bit_cnt==7`, pulse `rx_valid_o` with `rx_data_o`=`sr`, then enter GAP if `last`, otherwise HOLD. Else increment `bit_cnt` and enter HIGH.
- HOLD: csb=0, sck=0, ready=1. Wait indefinitely. On accept, load as in IDLE and enter LEAD. CSB stays low.
- GAP: csb=1, sck=0, ready=0. On tick, enter IDLE.
- `tx_data_i`/`tx_last_i` are sampled only on accept. Changes at other times are ignored.
- `tx_valid_i` held during LEAD/HIGH/LOW/GAP is not accepted until IDLE or HOLD.
- `rx_data_o` holds its value until the next byte completes.

## Timing
- All SPI outputs, `rx_valid_o`, `rx_data_o`, and `busy_o` are registered. `tx_ready_o` is decoded from the state register.
- While `rst_i` is high, and on the cycle after it: csb=1, sck=0, mosi=0, rx_valid=0, rx_data=0x00, busy=0, state=IDLE. `tx_ready_o`=0 while `rst_i` is high, and 1 from the first cycle after it.
- Reset mid-byte aborts the transfer: CSB high on the next cycle, no `rx_valid_o` pulse, and partial data is discarded.
- With D=`ClkDiv` and the accept at cycle 0:
  - LEAD occupies cycles 1..D.
  - Bit n HIGH occupies D+1+2nD .. 2D+2nD; LOW occupies the following D cycles.
  - Last LOW ends at cycle 17D; `rx_valid_o` is high at cycle 17D+1.
  - Single-byte frame: GAP occupies 17D+1..18D; `tx_ready_o`=1 at 18D+1.
  - In-frame follow-on byte: accept in HOLD at cycle 17D+1 at the earliest.
- SCK period is 2D cycles. D=1 must work: SCK toggles every cycle, and LEAD and GAP last 1 cycle each.

## Structure
- Package `spi_host_pkg`: `spi_host_state_e` enum (the six states) and `SpiByteW = 8`.
- Sub-module `spi_host_tick`: half-period counter with `clr_i`/`tick_o`. Counter width is `$clog2(ClkDiv)`, minimum 1.
- Everything else (FSM, shift register, bit counter) stays in `spi_host_byte`. Expected size is about 200 lines.

## Test plan
- D=4, send 0xA5 with `last`=1, and the device model returns 0x3C. Required: the model receives 0xA5; `rx_valid_o` is high only at cycle 69 with 0x3C; CSB is low for cycles 1..68; `tx_ready_o` returns at cycle 73.
- D=4, two-byte frame 0x12 (`last`=0) then 0x34 (`last`=1) with `tx_valid_i` held. Required: CSB never rises between the bytes, the second accept happens at cycle 69, and the model sees the stream 0x12,0x34.
- D=1, loopback (`spi_miso_i`=`spi_mosi_o`) with 0xFF, 0x00, 0x81. Required: each `rx_data_o` equals the byte sent, and SCK shows 8 rising edges per byte.
- HOLD with `tx_valid_i`=0 for 100 cycles. Required: CSB stays low, SCK stays low, and `tx_ready_o` stays 1.
- Assert `rst_i` during bit 3 of a byte. Required: CSB=1 and SCK=0 on the next cycle, no `rx_valid_o` pulse, and a fresh byte afterwards transfers correctly.
- `tx_valid_i` asserted during GAP. Required: no accept until IDLE, then a normal transfer.
